regfile_addr_seq: RTL and testbench
===================================

REGFILE_ADDR_SEQ -- requirements
Module: regfile_addr_seq

Interface
REQ-001 SHALL have parameter AW, default 3: register-file address width.
REQ-002 SHALL have parameter NCH, default 4: channel count; CHW = max(1, clog2(NCH)).
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1: global advance enable; low freezes all state and outputs.
REQ-006 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-007 SHALL have port cmd_op, input, 2: 00 WR_ERR, 01 WR_RES, 10 READ, 11 SHIFT.
REQ-008 SHALL have ports cmd_ch (input, CHW: channel select) and cmd_get (input, 1: READ single-operand mode).
REQ-009 SHALL have ports res_base and err_base, input, NCH*AW each: per-channel result/error register indices, channel k at bits [k*AW +: AW].
REQ-010 SHALL have ports ar1, ar2, ard, output, AW each: read-1, read-2 and write addresses.
REQ-011 SHALL have ports ar1_vld, ar2_vld, ard_vld, output, 1 each: address qualifiers (replace high-Z).
REQ-012 SHALL have ports busy (output, 1: FSM not IDLE) and done (output, 1: one-cycle completion pulse).

Function
REQ-013 SHALL accept a command when cmd_valid && cmd_ready && en; cmd_ready = (state==IDLE), registered.
REQ-014 SHALL latch cmd_op, cmd_ch, cmd_get and the selected channel's res/err base at acceptance; later base changes do not affect the command.
REQ-015 SHALL implement states IDLE, ISSUE, SHIFT, DONE; IDLE->ISSUE for WR_ERR/WR_RES/READ, IDLE->SHIFT for SHIFT, ISSUE->DONE, DONE->IDLE.
REQ-016 SHALL in ISSUE for READ drive ar1 = cmd_get ? res : res-1, ar1_vld=1; ar2 = err, ar2_vld = !cmd_get; ard_vld=0.
REQ-017 SHALL in ISSUE for WR_RES drive ard=res, for WR_ERR drive ard=err, with ard_vld=1, ar1_vld=ar2_vld=0.
REQ-018 SHALL in SHIFT step pointer p from res down to err+1, one step per enabled cycle: ard=p, ar1=p-1, ard_vld=ar1_vld=1, ar2_vld=0.
REQ-019 SHALL, for SHIFT with res==err, emit no valid cycle and go directly to DONE.
REQ-020 SHALL, for SHIFT with res<err, wrap modulo 2^AW (walk down through 0) unless the configuration in REQ-030 is enabled.
REQ-021 SHALL compute all decrements modulo 2^AW.
REQ-022 SHALL assert done exactly one cycle in DONE with all *_vld low; address values when *_vld low are don't-care but stable.
REQ-023 SHALL, while en low, hold state, pointer, addresses, qualifiers and done; done stays asserted until the DONE cycle is consumed.
REQ-024 SHALL issue outputs registered: address valid the cycle after acceptance (latency 1).
REQ-025 SHALL ignore cmd_valid while busy; no queuing.
REQ-026 SHALL treat cmd_ch >= NCH as channel 0.

Reset
REQ-027 SHALL on rst low, immediately: state IDLE, ar1=ar2=ard=0, all *_vld=0, done=0, busy=0, cmd_ready=0.
REQ-028 SHALL raise cmd_ready the first enabled cycle after rst release; reset mid-SHIFT abandons the command with no done.

Configuration
REQ-029 SHALL provide macro RF_ADDR_SAT_EN.
REQ-030 SHALL, with RF_ADDR_SAT_EN defined, saturate decrements at 0 (READ res=0, get=0 gives ar1=0) and treat SHIFT with res<err as zero-length; without it, wrap per REQ-020/021.

Structure
REQ-031 SHALL place op encoding, FSM state enumeration and default widths in shared package srcc_ctrl_pkg.
REQ-032 SHALL implement decrement (wrap/saturate) in sub-module rf_addr_dec, instantiated for ar1 and the SHIFT pointer.

Verification
REQ-033 SHALL cover: AW=3, ch2 res=5 err=2, READ get=0 -> next cycle ar1=4, ar2=2, ar1_vld=ar2_vld=1, ard_vld=0; done one cycle later.
REQ-034 SHALL cover: WR_ERR ch1 err=6 -> ard=6, ard_vld=1 for exactly one cycle, then done.
REQ-035 SHALL cover: SHIFT res=5 err=2 -> (ard,ar1)=(5,4),(4,3),(3,2) on three consecutive cycles, then done; SHIFT res=err=3 -> done only.
REQ-036 SHALL cover: READ res=0 get=0 -> ar1=7 without RF_ADDR_SAT_EN, ar1=0 with it.
REQ-037 SHALL cover: en low for 3 cycles mid-SHIFT -> outputs frozen, sequence resumes unchanged; rst low mid-SHIFT -> all outputs 0 asynchronously, no done.

Source files
------------

// File: rtl/srcc_ctrl_pkg.sv
// Shared encodings for the sequencing controllers: command ops, FSM states, default widths.
package srcc_ctrl_pkg;

    localparam int AW_DEF  = 3;
    localparam int NCH_DEF = 4;

    typedef enum logic [1:0] {
        OP_WR_ERR = 2'b00,
        OP_WR_RES = 2'b01,
        OP_READ   = 2'b10,
        OP_SHIFT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Channel-select width; a single channel still needs a 1-bit select port.
    function automatic int ch_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/rf_addr_dec.sv
// Register-index decrement: wraps modulo 2^AW, or saturates at 0 when RF_ADDR_SAT_EN is defined.
module rf_addr_dec
    import srcc_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] a_i,
    output logic [AW-1:0] y_o
);

`ifdef RF_ADDR_SAT_EN
    assign y_o = (a_i == '0) ? '0 : a_i - AW'(1);
`else
    assign y_o = a_i - AW'(1);
`endif

endmodule

// File: rtl/regfile_addr_seq.sv
// Register-file address sequencer: READ / WR_RES / WR_ERR single issue and multi-cycle SHIFT walk.
// Build option RF_ADDR_SAT_EN: decrements saturate at 0 and a SHIFT with res<err is zero-length.
//
// state    | meaning
// ST_IDLE  | cmd_ready high, waiting for a command
// ST_ISSUE | one cycle of READ / WR_* addresses on the outputs
// ST_SHIFT | walking pointer from res down to err+1
// ST_DONE  | done pulse, all qualifiers low
module regfile_addr_seq
    import srcc_ctrl_pkg::*;
#(
    parameter  int AW  = AW_DEF,
    parameter  int NCH = NCH_DEF,
    localparam int CHW = ch_width(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CHW-1:0]    cmd_ch,
    input  logic              cmd_get,
    input  logic [NCH*AW-1:0] res_base,
    input  logic [NCH*AW-1:0] err_base,
    output logic [AW-1:0]     ar1,
    output logic [AW-1:0]     ar2,
    output logic [AW-1:0]     ard,
    output logic              ar1_vld,
    output logic              ar2_vld,
    output logic              ard_vld,
    output logic              busy,
    output logic              done
);

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   err_q, err_d;
    logic [AW-1:0]   ar1_q, ar1_d, ar2_q, ar2_d, ard_q, ard_d;
    logic            ar1_vld_q, ar1_vld_d, ar2_vld_q, ar2_vld_d, ard_vld_q, ard_vld_d;
    logic            done_q, done_d;
    logic            rdy_q;

    logic [AW-1:0]   res_sel, err_sel;
    logic [AW-1:0]   ptr_dec, ar1_src, ar1_dec;
    logic            accept, zero_len;

    // Out-of-range channel selects fall back to channel 0.
    always_comb begin
        res_sel = res_base[AW-1:0];
        err_sel = err_base[AW-1:0];
        for (int k = 1; k < NCH; k++) begin
            if (cmd_ch == CHW'(k)) begin
                res_sel = res_base[k*AW +: AW];
                err_sel = err_base[k*AW +: AW];
            end
        end
    end

    assign accept = en && cmd_valid && rdy_q;

`ifdef RF_ADDR_SAT_EN
    assign zero_len = (res_sel <= err_sel);
`else
    assign zero_len = (res_sel == err_sel);
`endif

    rf_addr_dec #(.AW(AW)) u_ptr_dec (.a_i(ptr_q),   .y_o(ptr_dec));
    rf_addr_dec #(.AW(AW)) u_ar1_dec (.a_i(ar1_src), .y_o(ar1_dec));

    // ar1 is always one below the write/base index about to be presented.
    always_comb begin
        ar1_src = res_sel;
        if (state_q == ST_SHIFT) ar1_src = ptr_dec;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        ar1_d     = ar1_q;
        ar2_d     = ar2_q;
        ard_d     = ard_q;
        ar1_vld_d = 1'b0;
        ar2_vld_d = 1'b0;
        ard_vld_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ptr_d = res_sel;
                    err_d = err_sel;
                    case (op_e'(cmd_op))
                        OP_READ: begin
                            state_d   = ST_ISSUE;
                            ar1_d     = cmd_get ? res_sel : ar1_dec;
                            ar1_vld_d = 1'b1;
                            ar2_d     = err_sel;
                            ar2_vld_d = !cmd_get;
                        end
                        OP_WR_RES: begin
                            state_d   = ST_ISSUE;
                            ard_d     = res_sel;
                            ard_vld_d = 1'b1;
                        end
                        OP_WR_ERR: begin
                            state_d   = ST_ISSUE;
                            ard_d     = err_sel;
                            ard_vld_d = 1'b1;
                        end
                        default: begin
                            if (zero_len) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d   = ST_SHIFT;
                                ard_d     = res_sel;
                                ar1_d     = ar1_dec;
                                ard_vld_d = 1'b1;
                                ar1_vld_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_SHIFT: begin
                if (ptr_dec == err_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    ptr_d     = ptr_dec;
                    ard_d     = ptr_dec;
                    ar1_d     = ar1_dec;
                    ard_vld_d = 1'b1;
                    ar1_vld_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Everything advances only on enabled cycles, so en low freezes outputs and done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            err_q     <= '0;
            ar1_q     <= '0;
            ar2_q     <= '0;
            ard_q     <= '0;
            ar1_vld_q <= 1'b0;
            ar2_vld_q <= 1'b0;
            ard_vld_q <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            ar1_q     <= ar1_d;
            ar2_q     <= ar2_d;
            ard_q     <= ard_d;
            ar1_vld_q <= ar1_vld_d;
            ar2_vld_q <= ar2_vld_d;
            ard_vld_q <= ard_vld_d;
            done_q    <= done_d;
            rdy_q     <= (state_d == ST_IDLE);
        end
    end

    assign cmd_ready = rdy_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign ar1       = ar1_q;
    assign ar2       = ar2_q;
    assign ard       = ard_q;
    assign ar1_vld   = ar1_vld_q;
    assign ar2_vld   = ar2_vld_q;
    assign ard_vld   = ard_vld_q;

endmodule

// File: tb/tb_regfile_addr_seq.sv
// Bench for regfile_addr_seq: directed literal cases plus randomized traffic against a beat-list model.
module tb_regfile_addr_seq;

    localparam int AW  = 3;
    localparam int NCH = 3;
    localparam int CHW = 2;

    logic              clk;
    logic              rst;
    logic              en;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CHW-1:0]    cmd_ch;
    logic              cmd_get;
    logic [NCH*AW-1:0] res_base;
    logic [NCH*AW-1:0] err_base;
    logic [AW-1:0]     ar1, ar2, ard;
    logic              ar1_vld, ar2_vld, ard_vld, busy, done;

    regfile_addr_seq #(.AW(AW), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_get(cmd_get),
        .res_base(res_base), .err_base(err_base),
        .ar1(ar1), .ar2(ar2), .ard(ard),
        .ar1_vld(ar1_vld), .ar2_vld(ar2_vld), .ard_vld(ard_vld),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model: one expected beat per enabled cycle ----------------
    typedef struct packed {
        logic          rdy;
        logic          busy;
        logic          done;
        logic          v1;
        logic          v2;
        logic          vd;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] ad;
    } beat_t;

    beat_t beats[$];
    beat_t cur;

    function automatic beat_t mk(input bit v1, input bit v2, input bit vd,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [AW-1:0] ad, input bit dn);
        beat_t b;
        b.rdy = 1'b0; b.busy = 1'b1; b.done = dn;
        b.v1 = v1; b.v2 = v2; b.vd = vd;
        b.a1 = a1; b.a2 = a2; b.ad = ad;
        return b;
    endfunction

    function automatic logic [AW-1:0] model_dec(input logic [AW-1:0] x);
`ifdef RF_ADDR_SAT_EN
        return (x == 0) ? '0 : x - 1'b1;
`else
        return x - 1'b1;
`endif
    endfunction

    function automatic void push_cmd();
        int            ch;
        int            n;
        logic [AW-1:0] r, e, p;
        ch = (int'(cmd_ch) >= NCH) ? 0 : int'(cmd_ch);
        r  = res_base[ch*AW +: AW];
        e  = err_base[ch*AW +: AW];
        case (cmd_op)
            2'b10: beats.push_back(mk(1, !cmd_get, 0, cmd_get ? r : model_dec(r), e, 0, 0));
            2'b01: beats.push_back(mk(0, 0, 1, 0, 0, r, 0));
            2'b00: beats.push_back(mk(0, 0, 1, 0, 0, e, 0));
            default: begin
`ifdef RF_ADDR_SAT_EN
                n = (r > e) ? int'(r) - int'(e) : 0;
`else
                n = (int'(r) - int'(e) + (1 << AW)) % (1 << AW);
`endif
                for (int i = 0; i < n; i++) begin
                    p = r - AW'(i);
                    beats.push_back(mk(1, 0, 1, p - 1'b1, 0, p, 0));
                end
            end
        endcase
        beats.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats.delete();
            cur = '0;
        end else if (en) begin
            if (beats.size() > 0) begin
                cur = beats.pop_front();
            end else if (cur.rdy && cmd_valid) begin
                push_cmd();
                cur = beats.pop_front();
            end else begin
                cur = '0;
                cur.rdy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("cmd_ready", cmd_ready, cur.rdy);
            check("busy", busy, cur.busy);
            check("done", done, cur.done);
            check("ar1_vld", ar1_vld, cur.v1);
            check("ar2_vld", ar2_vld, cur.v2);
            check("ard_vld", ard_vld, cur.vd);
            if (cur.v1) check("ar1", ar1, cur.a1);
            if (cur.v2) check("ar2", ar2, cur.a2);
            if (cur.vd) check("ard", ard, cur.ad);
        end
    end

    // ---------------- directed helpers ----------------
    function automatic void set_ch(input int k, input logic [AW-1:0] r, input logic [AW-1:0] e);
        res_base[k*AW +: AW] = r;
        err_base[k*AW +: AW] = e;
    endfunction

    task automatic issue(input logic [1:0] op, input int ch, input bit get);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_mis++;
            $display("FAIL issue_timeout: cmd_ready stayed %0d, expected 1 (t=%0t)", cmd_ready, $time);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = CHW'(ch);
        cmd_get   = get;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic lit(input string tag, input bit v1, input bit v2, input bit vd,
                       input int a1, input int a2, input int ad, input bit dn);
        check({tag, ".ar1_vld"}, ar1_vld, v1);
        check({tag, ".ar2_vld"}, ar2_vld, v2);
        check({tag, ".ard_vld"}, ard_vld, vd);
        check({tag, ".done"}, done, dn);
        check({tag, ".busy"}, busy, 1);
        if (v1) check({tag, ".ar1"}, ar1, a1);
        if (v2) check({tag, ".ar2"}, ar2, a2);
        if (vd) check({tag, ".ard"}, ard, ad);
    endtask

    task automatic all_zero(input string tag);
        check({tag, ".ar1"}, ar1, 0);
        check({tag, ".ar2"}, ar2, 0);
        check({tag, ".ard"}, ard, 0);
        check({tag, ".vld"}, {ar1_vld, ar2_vld, ard_vld}, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ch = '0; cmd_get = 1'b0;
        res_base = '0; err_base = '0;
        set_ch(0, 3, 3);
        set_ch(1, 0, 6);
        set_ch(2, 5, 2);
        #1 rst = 1'b0;
        #1 all_zero("reset");
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        // READ get=0 on ch2
        issue(2'b10, 2, 0);
        lit("read_ch2", 1, 1, 0, 4, 2, 0, 0);
        @(negedge clk); lit("read_ch2_done", 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); check("read_ch2_idle", busy, 0);

        // WR_ERR on ch1
        issue(2'b00, 1, 0);
        lit("wr_err", 0, 0, 1, 0, 0, 6, 0);
        @(negedge clk); lit("wr_err_done", 0, 0, 0, 0, 0, 0, 1);

        // SHIFT 5 -> 2
        issue(2'b11, 2, 0);
        lit("shift_s0", 1, 0, 1, 4, 0, 5, 0);
        @(negedge clk); lit("shift_s1", 1, 0, 1, 3, 0, 4, 0);
        @(negedge clk); lit("shift_s2", 1, 0, 1, 2, 0, 3, 0);
        @(negedge clk); lit("shift_done", 0, 0, 0, 0, 0, 0, 1);

        // channel 3 is out of range -> ch0 (res=err=3): done only
        issue(2'b11, 3, 0);
        lit("shift_zero", 0, 0, 0, 0, 0, 0, 1);

        // READ res=0 get=0
        issue(2'b10, 1, 0);
`ifdef RF_ADDR_SAT_EN
        lit("read_res0", 1, 1, 0, 0, 6, 0, 0);
`else
        lit("read_res0", 1, 1, 0, 7, 6, 0, 0);
`endif

        // READ get=1
        issue(2'b10, 2, 1);
        lit("read_get", 1, 0, 0, 5, 0, 0, 0);

        // SHIFT with base change after acceptance and an en-low stall
        issue(2'b11, 2, 0);
        set_ch(2, 7, 0);
        lit("stall_s0", 1, 0, 1, 4, 0, 5, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); lit("stall_hold", 1, 0, 1, 4, 0, 5, 0);
        end
        en = 1'b1;
        @(negedge clk); lit("stall_s1", 1, 0, 1, 3, 0, 4, 0);
        @(negedge clk); lit("stall_s2", 1, 0, 1, 2, 0, 3, 0);
        @(negedge clk); lit("stall_done", 0, 0, 0, 0, 0, 0, 1);
        en = 1'b0;
        @(negedge clk); lit("done_hold", 0, 0, 0, 0, 0, 0, 1);
        en = 1'b1;
        @(negedge clk); check("done_release", done, 0);
        set_ch(2, 5, 2);

        // reset mid-SHIFT
        issue(2'b11, 2, 0);
        lit("rst_s0", 1, 0, 1, 4, 0, 5, 0);
        #2 rst = 1'b0;
        #1 all_zero("rst_mid_shift");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("no_done_after_rst", done, 0);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            en        = ($urandom_range(0, 9) != 0);
            cmd_valid = $urandom_range(0, 1);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_ch    = CHW'($urandom_range(0, 3));
            cmd_get   = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                res_base = (NCH*AW)'($urandom);
                err_base = (NCH*AW)'($urandom);
            end
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
